// File: rtl/vfd_scanout.sv
// VFD frame scanout: walks 640x480@60 timing, fetches RGB332 pixels from VRAM and
// emits RGB888 with syncs, blanks and DE aligned to the VRAM read latency.
module vfd_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned RAM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  output logic [18:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_din,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        HS,
  output logic        VS,
  output logic        HBlank,
  output logic        VBlank,
  output logic        DE
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);

  localparam logic [HCW-1:0] HActive    = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HSyncStart = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HSyncEnd   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] HLast      = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] VActive    = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VSyncStart = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VSyncEnd   = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] VLast      = VCW'(V_TOTAL - 1);

  // Pipeline flag bits: {active, hs_n, vs_n, hblank, vblank}; idle is blanked, syncs high.
  localparam logic [4:0] PipeIdle = 5'b01111;

  logic [HCW-1:0] hc_q;
  logic [VCW-1:0] vc_q;
  logic [18:0]    addr_cnt_q;
  logic           rd_q;
  logic           h_act, v_act, active, h_last, v_last;
  logic [4:0]     stage0;
  logic [4:0]     pipe_q [RAM_LAT+1];
  logic [4:0]     tail;

  // Stage 0: region and sync flags decoded from the raw counters.
  always_comb begin
    h_act  = hc_q < HActive;
    v_act  = vc_q < VActive;
    active = h_act && v_act;
    h_last = hc_q == HLast;
    v_last = vc_q == VLast;
    stage0 = {active,
              ~((hc_q >= HSyncStart) && (hc_q < HSyncEnd)),
              ~((vc_q >= VSyncStart) && (vc_q < VSyncEnd)),
              ~h_act,
              ~v_act};
    tail   = pipe_q[RAM_LAT];
  end

  // Horizontal / vertical raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (ce_pix) begin
      if (h_last) begin
        hc_q <= '0;
        vc_q <= v_last ? '0 : vc_q + 1'b1;
      end else begin
        hc_q <= hc_q + 1'b1;
      end
    end
  end

  // Linear address counter replaces line*H_ACTIVE+column; restarts at every frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt_q <= '0;
      vram_addr  <= '0;
      rd_q       <= 1'b0;
    end else if (ce_pix) begin
      rd_q <= active;
      if (active) begin
        vram_addr  <= addr_cnt_q;
        addr_cnt_q <= addr_cnt_q + 19'd1;
      end
      if (h_last && v_last) addr_cnt_q <= '0;
    end
  end

  // Strobe only on ce ticks so the RAM sees exactly one request per fetched pixel.
  assign vram_rd = rd_q & ce_pix;

  // Delay the timing flags so they meet the pixel data coming back from VRAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i <= RAM_LAT; i++) pipe_q[i] <= PipeIdle;
    end else if (ce_pix) begin
      pipe_q[0] <= stage0;
      for (int unsigned i = 1; i <= RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Output register: colour expansion and timing outputs update on the capture tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      R      <= '0;
      G      <= '0;
      B      <= '0;
      HS     <= 1'b1;
      VS     <= 1'b1;
      HBlank <= 1'b1;
      VBlank <= 1'b1;
      DE     <= 1'b0;
    end else if (ce_pix) begin
      DE     <= tail[4];
      HS     <= tail[3];
      VS     <= tail[2];
      HBlank <= tail[1];
      VBlank <= tail[0];
      if (tail[4]) begin
        R <= {vram_din[7:5], vram_din[7:5], vram_din[7:6]};
        G <= {vram_din[4:2], vram_din[4:2], vram_din[4:3]};
        B <= {4{vram_din[1:0]}};
      end else begin
        R <= '0;
        G <= '0;
        B <= '0;
      end
    end
  end

endmodule
